// File: rtl/puf_response_collector.sv
// puf_response_collector: drives a ring-oscillator PUF, one challenge per key
// word (seed + word index, mod 256). It waits for a rising edge on puf_ready,
// stores each 8-bit response, and presents the assembled key with key_valid.
// Optional majority voting is enabled by the PUF_MAJORITY_VOTE_EN macro: each
// challenge is evaluated VOTES times and every key bit is resolved by majority.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle request; accepted only in IDLE or DONE
//   seed          base challenge, sampled on an accepted start
//   puf_response  PUF response byte, captured on a puf_ready rising edge
//   puf_ready     PUF ready level
//   puf_en        PUF oscillator enable (registered)
//   chall_out     challenge to the PUF (registered)
//   key           assembled key, word i at key[8i+7:8i] (registered)
//   key_valid     key complete and stable (registered)
//   busy          generation in progress (registered)
//   err           last generation ended in a timeout (registered)
module puf_response_collector #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned VOTES     = 3,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             seed,
    input  logic [7:0]             puf_response,
    input  logic                   puf_ready,
    output logic                   puf_en,
    output logic [7:0]             chall_out,
    output logic [8*NUM_WORDS-1:0] key,
    output logic                   key_valid,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned KEY_W     = 8 * NUM_WORDS;
    localparam logic [3:0]  LAST_WORD = 4'(NUM_WORDS - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    // Elaboration-time guard on the voting parameter.
    if ((VOTES % 2) == 0 || VOTES > 15) begin : g_bad_votes
        $error("VOTES must be odd and at most 15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [7:0]         seed_q;
    logic [7:0]         resp_q;
    logic [7:0]         chall_q;
    logic [3:0]         word_idx_q;
    logic [15:0]        tmo_q;
    logic               ready_prev_q;
    logic               puf_en_q;
    logic               busy_q;
    logic               key_valid_q;
    logic               err_q;
    logic [KEY_W-1:0]   key_q;

    logic               capture_c;
    logic               eval_done_c;
    logic [7:0]         store_byte_c;

    // A capture needs a fresh rising edge; a level held high is not a response.
    assign capture_c = puf_ready & ~ready_prev_q;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [3:0] LAST_VOTE = 4'(VOTES - 1);
    localparam logic [3:0] HALF      = 4'(VOTES / 2);

    logic [3:0] vote_idx_q;
    logic [3:0] vcnt_q [8];
    logic [3:0] vsum_c [8];

    // Per-bit tallies including the byte captured for this evaluation.
    always_comb begin
        store_byte_c = '0;
        for (int b = 0; b < 8; b++) begin
            vsum_c[b]       = vcnt_q[b] + 4'(resp_q[b]);
            store_byte_c[b] = (vsum_c[b] > HALF);
        end
    end

    assign eval_done_c = (vote_idx_q == LAST_VOTE);
`else
    assign store_byte_c = resp_q;
    assign eval_done_c  = 1'b1;
`endif

    // Main controller: state, PUF handshake, key assembly and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            seed_q       <= '0;
            resp_q       <= '0;
            chall_q      <= '0;
            word_idx_q   <= '0;
            tmo_q        <= '0;
            ready_prev_q <= 1'b0;
            puf_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            key_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            key_q        <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_idx_q   <= '0;
            for (int b = 0; b < 8; b++) vcnt_q[b] <= '0;
`endif
        end else begin
            ready_prev_q <= puf_ready;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        seed_q      <= seed;
                        chall_q     <= seed;
                        word_idx_q  <= '0;
                        key_q       <= '0;
                        key_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        puf_en_q    <= 1'b1;
                        state_q     <= S_ISSUE;
`ifdef PUF_MAJORITY_VOTE_EN
                        vote_idx_q  <= '0;
                        for (int b = 0; b < 8; b++) vcnt_q[b] <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture_c) begin
                        resp_q   <= puf_response;
                        puf_en_q <= 1'b0;
                        state_q  <= S_STORE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q       <= 1'b1;
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        puf_en_q    <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_STORE: begin
                    if (!eval_done_c) begin
                        // Re-evaluate the same challenge; chall_out is left untouched.
`ifdef PUF_MAJORITY_VOTE_EN
                        for (int b = 0; b < 8; b++) vcnt_q[b] <= vsum_c[b];
                        vote_idx_q <= vote_idx_q + 4'd1;
`endif
                        puf_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end else begin
                        for (int w = 0; w < int'(NUM_WORDS); w++) begin
                            if (word_idx_q == 4'(w)) key_q[w*8 +: 8] <= store_byte_c;
                        end
                        if (word_idx_q < LAST_WORD) begin
                            word_idx_q <= word_idx_q + 4'd1;
                            chall_q    <= seed_q + 8'(word_idx_q) + 8'd1;
                            puf_en_q   <= 1'b1;
                            state_q    <= S_ISSUE;
`ifdef PUF_MAJORITY_VOTE_EN
                            vote_idx_q <= '0;
                            for (int b = 0; b < 8; b++) vcnt_q[b] <= '0;
`endif
                        end else begin
                            busy_q      <= 1'b0;
                            key_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign puf_en    = puf_en_q;
    assign chall_out = chall_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
